// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream to instruction-memory loader; holds the core in reset until the image is in.
// Latency: imem_we_o pulses the cycle after lane 3 of a word is accepted; done_o/err_o rise the cycle after the final byte.
// Backpressure: rx_ready_o is high while loading and never drops mid-image; it is low in DONE/ERR and while rst_i is high.
//
// Optional feature macro: IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte and the CSUM state.
//
// Ports:
//   clk_i, rst_i            single clock, synchronous active-high reset
//   rx_data_i/valid/ready   byte stream in; transfer on rx_valid_i & rx_ready_o
//   imem_we_o/addr_o/data_o one-cycle write strobe, byte address (multiple of 4), 32-bit word
//   cpu_rst_o               core reset, high until a successful load
//   done_o, err_o           sticky completion / failure flags
module imem_loader #(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  // State entered once the payload is exhausted (or the count is zero).
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t AFTER_PAYLOAD = CSUM;
`else
  localparam state_t AFTER_PAYLOAD = DONE;
`endif

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  lane_q;
  logic [23:0] partial_q;
  logic        accept;
  logic [15:0] hdr_count;
  logic        last_word;
  logic [ADDR_W-1:0] byte_addr;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept    = rx_valid_i & rx_ready_o;
  // Full count as it will be once the high byte in HDR1 is latched.
  assign hdr_count = {rx_data_i, count_q[7:0]};
  // count_q >= 1 whenever DATA is active, so count-1 never wraps there.
  assign last_word = (word_idx_q == (count_q - 16'd1));

  // Byte address = word index * 4, zero-extended or truncated to ADDR_W.
  generate
    if (ADDR_W > 18) begin : g_addr_wide
      assign byte_addr = {{(ADDR_W-18){1'b0}}, word_idx_q, 2'b00};
    end else begin : g_addr_narrow
      logic [17:0] full_addr;
      assign full_addr = {word_idx_q, 2'b00};
      assign byte_addr = full_addr[ADDR_W-1:0];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR0: begin
        if (accept) state_d = HDR1;
      end
      HDR1: begin
        if (accept) begin
          if ({16'd0, hdr_count} > MAX_WORDS_W) begin
            state_d = ERR;
          end else if (hdr_count == 16'd0) begin
            state_d = AFTER_PAYLOAD;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept && (lane_q == 2'd3) && last_word) state_d = AFTER_PAYLOAD;
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (accept) state_d = (rx_data_i == csum_q) ? DONE : ERR;
      end
`endif
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // Datapath: header latch, word assembly, write strobe, running checksum.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= 16'd0;
      word_idx_q  <= 16'd0;
      lane_q      <= 2'd0;
      partial_q   <= 24'd0;
      imem_we_o   <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= 32'd0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      imem_we_o <= 1'b0;
      case (state_q)
        HDR0: begin
          lane_q     <= 2'd0;
          word_idx_q <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_q     <= 8'd0;
`endif
          if (accept) count_q[7:0] <= rx_data_i;
        end
        HDR1: begin
          if (accept) count_q[15:8] <= rx_data_i;
        end
        DATA: begin
          if (accept) begin
            lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q <= csum_q ^ rx_data_i;
`endif
            case (lane_q)
              2'd0: partial_q[7:0]   <= rx_data_i;
              2'd1: partial_q[15:8]  <= rx_data_i;
              2'd2: partial_q[23:16] <= rx_data_i;
              default: begin
                // Write goes out next cycle while the next word's bytes keep flowing.
                imem_we_o   <= 1'b1;
                imem_addr_o <= byte_addr;
                imem_data_o <= {rx_data_i, partial_q};
                word_idx_q  <= word_idx_q + 16'd1;
              end
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rx_ready_o = !rst_i && (state_q != DONE) && (state_q != ERR);
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == ERR);
  assign cpu_rst_o  = !done_o;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus hand-written multi-cycle sequences for imem_loader.
// Latency: each vector is one clock; outputs are sampled 1 time unit after the rising edge.
// Backpressure: rx_ready_o is sampled before the edge, write pulses are collected on the falling edge.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_o;
  logic        cpu_rst_o;
  logic        done_o;
  logic        err_o;

  imem_loader #(.ADDR_W(32), .MAX_WORDS(256)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .cpu_rst_o   (cpu_rst_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: captures every strobe and counts strobes wider than one cycle.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wide_pulses = 0;
  logic        we_prev = 1'b0;

  always @(negedge clk_i) begin
    if (imem_we_o) begin
      wr_addr.push_back(imem_addr_o);
      wr_data.push_back(imem_data_o);
      if (we_prev) wide_pulses++;
    end
    we_prev = imem_we_o;
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wide_pulses = 0;
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;   // expected before the edge
    logic        we;    // expected after the edge
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vec[$];

  task automatic add_vec(input logic rst, input logic vld, input logic [7:0] dat,
                         input logic rdy, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic done, input logic err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.rdy = rdy; v.we = we;
    v.addr = addr; v.wdat = wdat; v.done = done; v.err = err;
    vec.push_back(v);
  endtask

  task automatic step(input logic rst, input logic vld, input logic [7:0] dat);
    rst_i = rst; rx_valid_i = vld; rx_data_i = dat;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img3[14];
    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;

    // A: single word 0x00000013.
    add_vec(1, 0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h01, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h13, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0);
`ifdef IMEM_LOADER_CSUM_EN
    add_vec(0, 1, 8'h00, 1, 1, 32'h0, 32'h13, 0, 0);
    add_vec(0, 1, 8'h13, 1, 0, 32'h0, 32'h13, 1, 0);
`else
    add_vec(0, 1, 8'h00, 1, 1, 32'h0, 32'h13, 1, 0);
`endif
    add_vec(0, 1, 8'hAA, 0, 0, 32'h0, 32'h13, 1, 0);
    // B: zero count.
    add_vec(1, 0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0);
`ifdef IMEM_LOADER_CSUM_EN
    add_vec(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 1, 0);
`else
    add_vec(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 1, 0);
`endif
    add_vec(0, 1, 8'h55, 0, 0, 32'h0, 32'h0, 1, 0);
    // C: count 257 is oversized.
    add_vec(1, 0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h01, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h01, 1, 0, 32'h0, 32'h0, 0, 1);
    add_vec(0, 1, 8'h00, 0, 0, 32'h0, 32'h0, 0, 1);
    add_vec(0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 1);
    // D: count 256 is the largest accepted.
    add_vec(1, 0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h01, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(0, 1, 8'h77, 1, 0, 32'h0, 32'h0, 0, 0);
    add_vec(1, 1, 8'h77, 0, 0, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < vec.size(); i++) begin
      rst_i = vec[i].rst; rx_valid_i = vec[i].vld; rx_data_i = vec[i].dat;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, rx_ready_o}, {31'd0, vec[i].rdy});
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_we", i),      {31'd0, imem_we_o}, {31'd0, vec[i].we});
      chk($sformatf("v%0d_addr", i),    imem_addr_o, vec[i].addr);
      chk($sformatf("v%0d_data", i),    imem_data_o, vec[i].wdat);
      chk($sformatf("v%0d_done", i),    {31'd0, done_o}, {31'd0, vec[i].done});
      chk($sformatf("v%0d_err", i),     {31'd0, err_o}, {31'd0, vec[i].err});
      chk($sformatf("v%0d_cpu_rst", i), {31'd0, cpu_rst_o}, {31'd0, !vec[i].done});
    end

    // Count 3 with valid toggling every other cycle; idle cycles carry junk data.
    step(1'b1, 1'b0, 8'h00);
    clear_mon();
    img3[0] = 8'h03; img3[1] = 8'h00;
    for (int i = 0; i < 12; i++) img3[i+2] = 8'(i + 1);
    for (int i = 0; i < 14; i++) begin
      send(img3[i]);
      step(1'b0, 1'b0, 8'hFF);
    end
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h0C);
`endif
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("c3_nwrites", wr_addr.size(), 32'd3);
    if (wr_addr.size() == 3) begin
      chk("c3_addr0", wr_addr[0], 32'h0);
      chk("c3_data0", wr_data[0], 32'h04030201);
      chk("c3_addr1", wr_addr[1], 32'h4);
      chk("c3_data1", wr_data[1], 32'h08070605);
      chk("c3_addr2", wr_addr[2], 32'h8);
      chk("c3_data2", wr_data[2], 32'h0C0B0A09);
    end
    chk("c3_wide_pulses", wide_pulses, 32'd0);
    chk("c3_done", {31'd0, done_o}, 32'd1);
    chk("c3_err", {31'd0, err_o}, 32'd0);
    chk("c3_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);

    // Reset mid-load after two payload bytes, then a fresh count-1 image.
    step(1'b1, 1'b0, 8'h00);
    clear_mon();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    step(1'b1, 1'b0, 8'h00);
    chk("rst_mid_done", {31'd0, done_o}, 32'd0);
    chk("rst_mid_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    send(8'h01); send(8'h00); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h22);
`endif
    step(1'b0, 1'b0, 8'h00);
    chk("rst_mid_nwrites", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("rst_mid_addr", wr_addr[0], 32'h0);
      chk("rst_mid_data", wr_data[0], 32'hEFBEADDE);
    end
    chk("rst_mid_done2", {31'd0, done_o}, 32'd1);
    chk("rst_mid_err", {31'd0, err_o}, 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
    // Checksum mismatch then match for payload 11 22 33 44 (XOR = 0x44).
    step(1'b1, 1'b0, 8'h00);
    send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h45);
    chk("cs_bad_err", {31'd0, err_o}, 32'd1);
    chk("cs_bad_done", {31'd0, done_o}, 32'd0);
    chk("cs_bad_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    chk("cs_bad_ready", {31'd0, rx_ready_o}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h44);
    chk("cs_good_done", {31'd0, done_o}, 32'd1);
    chk("cs_good_err", {31'd0, err_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
